// File: rtl/cnn_argmax_classifier.sv
// cnn_argmax_classifier: signed argmax over a framed stream of per-class scores.
// Ports: clk_in/rst_n; start; s_valid/s_ready/s_data/s_last; class_idx/class_score/
// class_valid/frame_err/busy/lat_cycles; second_idx/margin (macro ARGMAX_TOP2_EN).
module cnn_argmax_classifier #(
  parameter int DATA_W    = 16,
  parameter int NUM_CLASS = 10,
  parameter int CLS_W     = 4,
  parameter int CNT_W     = 20
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [CLS_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score,
  output logic              class_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  lat_cycles,
  output logic [CLS_W-1:0]  second_idx,
  output logic [DATA_W:0]   margin
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  // Low for the first edge after reset release so a start there is dropped.
  logic armed;

  logic [CLS_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] best, best_nx;
  logic [CLS_W-1:0]  best_idx, best_idx_nx;
  logic              take_start;
  logic              beat;
  logic              at_last;
  logic              final_beat;

  assign take_start = (state == IDLE) && start && armed;
  assign beat       = (state == RUN) && s_valid;
  assign at_last    = (idx == LAST_IDX);
  assign final_beat = beat && (s_last || at_last);
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_start) state_nx = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (final_beat) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Running best including the beat on the bus; ties keep the lower index.
  always_comb begin
    best_nx     = best;
    best_idx_nx = best_idx;
    if (idx == '0) begin
      best_nx     = s_data;
      best_idx_nx = '0;
    end else if ($signed(s_data) > $signed(best)) begin
      best_nx     = s_data;
      best_idx_nx = idx;
    end
  end

  // Results are registered on the final beat so they appear in DONE.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
      class_valid <= 1'b0;
      frame_err   <= 1'b0;
      lat_cycles  <= '0;
    end else begin
      armed       <= 1'b1;
      class_valid <= 1'b0;
      if (take_start) begin
        idx <= '0;
        cnt <= CNT_W'(1);
      end
      if (state == RUN) cnt <= cnt_inc;
      if (beat) begin
        best     <= best_nx;
        best_idx <= best_idx_nx;
        idx      <= idx + 1'b1;
      end
      if (final_beat) begin
        class_valid <= 1'b1;
        class_idx   <= best_idx_nx;
        class_score <= best_nx;
        lat_cycles  <= cnt_inc;
        frame_err   <= s_last ^ at_last;
      end
    end
  end

`ifdef ARGMAX_TOP2_EN
  logic [DATA_W-1:0] sec, sec_nx;
  logic [CLS_W-1:0]  sec_idx, sec_idx_nx;
  logic              sec_ok, sec_ok_nx;
  logic [DATA_W:0]   diff;

  // A displaced best becomes runner-up; sec_ok is low until a 2nd beat.
  always_comb begin
    sec_nx     = sec;
    sec_idx_nx = sec_idx;
    sec_ok_nx  = sec_ok;
    if (idx == '0) begin
      sec_nx     = '0;
      sec_idx_nx = '0;
      sec_ok_nx  = 1'b0;
    end else if ($signed(s_data) > $signed(best)) begin
      sec_nx     = best;
      sec_idx_nx = best_idx;
      sec_ok_nx  = 1'b1;
    end else if (!sec_ok || $signed(s_data) > $signed(sec)) begin
      sec_nx     = s_data;
      sec_idx_nx = idx;
      sec_ok_nx  = 1'b1;
    end
    diff = {best_nx[DATA_W-1], best_nx} - {sec_nx[DATA_W-1], sec_nx};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sec        <= '0;
      sec_idx    <= '0;
      sec_ok     <= 1'b0;
      second_idx <= '0;
      margin     <= '0;
    end else begin
      if (beat) begin
        sec     <= sec_nx;
        sec_idx <= sec_idx_nx;
        sec_ok  <= sec_ok_nx;
      end
      if (final_beat) begin
        second_idx <= sec_ok_nx ? sec_idx_nx : '0;
        margin     <= sec_ok_nx ? diff : '0;
      end
    end
  end
`else
  assign second_idx = '0;
  assign margin     = '0;
`endif

endmodule

// File: doc/cnn_argmax_classifier.md
Name: cnn_argmax_classifier

Overview:
- Parametrised decision stage that replaces the fixed 4-bit class output of the CNN top.
- Consumes the final fully-connected layer's per-class scores as a valid/ready stream and computes the signed argmax over NUM_CLASS scores.
- Measures inference latency in clk_in cycles from frame start to decision.
- Presents the latched class index, winning score, latency and framing error to the top level and benches.

Parameters:
- DATA_W, 16: width of signed two's-complement score.
- NUM_CLASS, 10: scores per frame, 2..2^CLS_W.
- CLS_W, 4: class index width.
- CNT_W, 20: latency counter width; saturating.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  frame-start pulse from the CNN controller.
- s_valid  input  1  score valid.
- s_ready  output  1  score accepted when s_valid && s_ready.
- s_data  input  DATA_W  signed class score, class order 0..NUM_CLASS-1.
- s_last  input  1  marks the final score of a frame.
- class_idx  output  CLS_W  winning class index, held until the next decision.
- class_score  output  DATA_W  winning score, held.
- class_valid  output  1  one-cycle pulse when class_idx/class_score update.
- frame_err  output  1  held; set on a framing mismatch of the last frame.
- busy  output  1  high in RUN.
- lat_cycles  output  CNT_W  cycles from start to decision, held.
- second_idx  output  CLS_W  runner-up index (optional feature).
- margin  output  DATA_W+1  best minus runner-up score (optional feature).

Behaviour:
- Reset state: all outputs 0, state IDLE, internal counters and best-score registers cleared.
  - Reset asserted mid-frame aborts immediately; no class_valid is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: s_ready=0. When start=1, go to RUN next cycle, clear the score index to 0, and set the latency counter to 1.
  - RUN: s_ready=1, busy=1. The latency counter increments every cycle and saturates at 2^CNT_W-1.
  - RUN, on each accepted beat with index n:
    - n==0 loads best=s_data, best_idx=0.
    - Otherwise best is replaced only if s_data > best (signed strictly greater). Ties keep the lower index.
  - RUN exits to DONE after the beat where n==NUM_CLASS-1 or s_last=1, whichever comes first.
  - DONE: one cycle. class_valid=1; class_idx, class_score, lat_cycles and frame_err update in this same cycle. s_ready=0. Next state is IDLE.
- Latency: class_valid is asserted the cycle after the final accepted beat.
  - Minimum start-to-class_valid is NUM_CLASS+1 cycles with back-to-back valid beats.
- frame_err is set for the frame if either:
  - s_last=1 on a beat with n<NUM_CLASS-1 (short frame), or
  - s_last=0 on beat n==NUM_CLASS-1 (missing last).
  - frame_err is otherwise cleared at DONE.
  - A short frame still produces a decision over the beats received.
- Other boundary rules:
  - start in RUN or DONE is ignored; it is not queued.
  - start coincident with the reset release edge is ignored.
  - s_valid in IDLE or DONE is not accepted (s_ready=0); upstream must hold the data.
  - Gaps in s_valid during RUN are permitted; the counter keeps running.

Optional Feature:
- Macro ARGMAX_TOP2_EN.
- When defined:
  - Tracks the runner-up as well. When best is replaced, the previous best moves to runner-up; otherwise s_data > runner-up (strict) replaces the runner-up.
  - At DONE, second_idx and margin = best - runner-up are latched (sign-extended, DATA_W+1 bits, never negative).
  - For a 1-beat frame, second_idx=0 and margin=0.
- When undefined: second_idx and margin are tied to 0 and no runner-up registers exist.

Test Plan:
- Reset then start, feed scores 3,-2,7,1,0,5,7,-8,2,4 back-to-back with s_last on the 10th beat:
  - class_valid pulse with class_idx=2, class_score=7, lat_cycles=11, frame_err=0.
  - With ARGMAX_TOP2_EN: second_idx=6, margin=0.
- All scores -32768 except index 9 = -32767: class_idx=9. All scores equal: class_idx=0.
- Same frame with s_valid low every other cycle: same class_idx=2; lat_cycles=20 (start pulse to class_valid = 20 cycles).
- Short frame, s_last on beat 4 with scores 1,9,2,3:
  - class_valid after the 4th beat, class_idx=1, frame_err=1.
  - A following correct frame clears frame_err to 0.
- Assert rst_n=0 after 5 beats: all outputs return to 0 asynchronously and no class_valid appears.
  - A new start then yields the correct result of a fresh frame.
- With CNT_W=4, stall s_valid for 30 cycles mid-frame: lat_cycles=15 (saturated). A start pulse during RUN has no effect.
